// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and the downstream 3-to-8 decoder.
package rr_arbiter_8_pkg;

   localparam int N_REQ        = 8;
   localparam int IDX_W        = 3;
   localparam int MAX_HOLD_DEF = 16;
   localparam int CNT_W_DEF    = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef logic [IDX_W-1:0] gnt_idx_t;

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Rotating fixed-priority picker: first set request at or above ptr, wrapping.
module rr_pick
   import rr_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  gnt_idx_t         ptr,
   output gnt_idx_t         idx,
   output logic             any
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   gnt_idx_t           off;

   always_comb begin
      dbl = {req, req};
      rot = N_REQ'(dbl >> ptr);
      off = '0;
      // Scan downward so the lowest set bit of the rotated vector wins.
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rot[i]) off = gnt_idx_t'(i);
      end
      idx = ptr + off;
      any = |req;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with hold watchdog and break-before-make grant gap.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   state_t           state_q, state_d;
   gnt_idx_t         ptr_q, ptr_d;
   gnt_idx_t         idx_d;
   logic             vld_d, to_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   gnt_idx_t         pick_idx;
   logic             pick_any;
   logic             rel_drop, rel_wd, rel;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign rel_drop = ~req[gnt_idx];
   assign rel_wd   = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD - 1));
   assign rel      = done | rel_drop | rel_wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_idx <= idx_d;
         gnt_vld <= vld_d;
         timeout <= to_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = GRANT;
         GRANT:   if (rel)      state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Every release returns to IDLE, which forces a gnt_vld=0 cycle before any re-grant.
   always_comb begin
      ptr_d  = ptr_q;
      idx_d  = gnt_idx;
      vld_d  = gnt_vld;
      hold_d = hold_q;
      to_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               idx_d  = pick_idx;
               vld_d  = 1'b1;
               hold_d = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               vld_d = 1'b0;
               ptr_d = gnt_idx + gnt_idx_t'(1);
               to_d  = rel_wd & ~done & ~rel_drop;
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            vld_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: vector table, directed corner sequences, random run vs reference model.
module tb_rr_arbiter_8;
   import rr_arbiter_8_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] idx_a, idx_b;
   logic       vld_a, vld_b, to_a, to_b;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
   );

   rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: owner (-1 = none), last granted, pointer, cycles held so far.
   int   m_owner[2];
   int   m_last[2];
   int   m_ptr[2];
   int   m_held[2];
   int   m_to[2];
   int   m_max[2] = '{16, 4};

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic       vld;
      logic [2:0] idx;
      logic       to;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_last[k]  = 0;
         m_ptr[k]   = 0;
         m_held[k]  = 0;
         m_to[k]    = 0;
      end
   endtask

   task automatic model_step(input int k, input logic [7:0] r, input logic d);
      int c;
      bit found, dr, wd;
      found = 0;
      if (m_owner[k] < 0) begin
         m_to[k] = 0;
         for (int j = 0; j < 8; j++) begin
            c = (m_ptr[k] + j) % 8;
            if (!found && r[c]) begin
               found      = 1;
               m_owner[k] = c;
               m_last[k]  = c;
               m_held[k]  = 1;
            end
         end
      end else begin
         dr = !r[m_owner[k]];
         wd = (m_max[k] != 0) && (m_held[k] == m_max[k]);
         if (d || dr || wd) begin
            m_to[k]    = (wd && !d && !dr) ? 1 : 0;
            m_ptr[k]   = (m_owner[k] + 1) % 8;
            m_owner[k] = -1;
         end else begin
            m_held[k]++;
            m_to[k] = 0;
         end
      end
   endtask

   task automatic cmp_models();
      chk("model_a_vld", int'(vld_a), (m_owner[0] >= 0) ? 1 : 0);
      chk("model_a_idx", int'(idx_a), m_last[0]);
      chk("model_a_to",  int'(to_a),  m_to[0]);
      chk("model_b_vld", int'(vld_b), (m_owner[1] >= 0) ? 1 : 0);
      chk("model_b_idx", int'(idx_b), m_last[1]);
      chk("model_b_to",  int'(to_b),  m_to[1]);
   endtask

   task automatic step(input logic [7:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
      if (rst_n) begin
         model_step(0, r, d);
         model_step(1, r, d);
      end
      cmp_models();
   endtask

   task automatic do_reset();
      req   = 8'hFF;
      done  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld_a", int'(vld_a), 0);
      chk("rst_idx_a", int'(idx_a), 0);
      chk("rst_to_a",  int'(to_a),  0);
      chk("rst_vld_b", int'(vld_b), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] r;
      logic       d;

      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      model_reset();

      // Single request, then next grant follows the advanced pointer.
      tbl.push_back('{1'b1, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
      tbl.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
      tbl.push_back('{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
      tbl.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 3'd5, 1'b0});
      tbl.push_back('{1'b0, 8'hFF, 1'b0, 1'b1, 3'd6, 1'b0});
      tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 3'd6, 1'b0});
      // Full rotation 0..7,0 with a gap row between every grant.
      for (int g = 0; g < 9; g++) begin
         tbl.push_back('{(g == 0), 8'hFF, 1'b0, 1'b1, 3'(g % 8), 1'b0});
         tbl.push_back('{1'b0,     8'hFF, 1'b0, 1'b1, 3'(g % 8), 1'b0});
         tbl.push_back('{1'b0,     8'hFF, 1'b1, 1'b0, 3'(g % 8), 1'b0});
      end
      // Pointer wrap from 7 to 0.
      tbl.push_back('{1'b1, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0});
      tbl.push_back('{1'b0, 8'h40, 1'b1, 1'b0, 3'd6, 1'b0});
      tbl.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h03, 1'b1, 1'b0, 3'd0, 1'b0});
      tbl.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd1, 1'b0});
      tbl.push_back('{1'b0, 8'h03, 1'b1, 1'b0, 3'd1, 1'b0});
      // Request drop releases without timeout; then a fresh grant.
      tbl.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0});
      tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0});
      tbl.push_back('{1'b0, 8'hFF, 1'b0, 1'b1, 3'd3, 1'b0});

      // Reset held with all requests, then idle with no requests.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(8'h00, 1'b0);
         chk("idle_vld", int'(vld_a), 0);
      end

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].req, tbl[i].done);
         chk($sformatf("vec%0d_vld", i), int'(vld_a), int'(tbl[i].vld));
         chk($sformatf("vec%0d_idx", i), int'(idx_a), int'(tbl[i].idx));
         chk($sformatf("vec%0d_to",  i), int'(to_a),  int'(tbl[i].to));
      end

      // Asynchronous reset mid-grant (grant to 3 is active from the last row).
      chk("pre_async_vld", int'(vld_a), 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_vld_a", int'(vld_a), 0);
      chk("async_vld_b", int'(vld_b), 0);
      chk("async_idx_a", int'(idx_a), 0);
      #2;
      rst_n = 1'b1;
      step(8'hFF, 1'b0);
      chk("post_async_vld", int'(vld_a), 1);
      chk("post_async_idx", int'(idx_a), 0);

      // Watchdog on the MAX_HOLD=4 instance.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(8'h08, 1'b0);
         chk("wd_hold_vld", int'(vld_b), 1);
         chk("wd_hold_idx", int'(idx_b), 3);
         chk("wd_hold_to",  int'(to_b),  0);
      end
      step(8'h08, 1'b0);
      chk("wd_fire_vld", int'(vld_b), 0);
      chk("wd_fire_to",  int'(to_b),  1);
      step(8'h08, 1'b0);
      chk("wd_regrant_vld", int'(vld_b), 1);
      chk("wd_regrant_idx", int'(idx_b), 3);
      chk("wd_regrant_to",  int'(to_b),  0);

      // Done coinciding with the watchdog limit suppresses timeout.
      do_reset();
      for (int i = 0; i < 4; i++) step(8'h08, 1'b0);
      step(8'h08, 1'b1);
      chk("wd_done_vld", int'(vld_b), 0);
      chk("wd_done_to",  int'(to_b),  0);

      // Random traffic with slowly changing request levels.
      do_reset();
      r = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) r = 8'($urandom);
         d = ($urandom_range(0, 9) == 0);
         step(r, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Eight-requester round-robin arbiter that sits directly upstream of the team's 3-to-8 one-hot decoder. It registers a 3-bit grant index and a grant-valid strobe. These connect straight to the decoder's select input and enable, so the decoder output is the one-hot grant vector. The block owns fairness, hold time, a hold-time watchdog, and a guaranteed break-before-make gap between consecutive grants.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 to match the decoder width.
IDX_W, 3, grant index width; equals log2(N_REQ).
MAX_HOLD, 16, maximum number of cycles a grant may stay valid; 0 disables the watchdog.
CNT_W, 5, hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  8  request vector; bit i = requester i, level-sensitive.
done  input  1  single-cycle release pulse from the current grant owner.
gnt_idx  output  3  registered grant index; connects to the decoder select input.
gnt_vld  output  1  registered grant valid; connects to the decoder enable.
timeout  output  1  registered one-cycle pulse; grant was revoked by the watchdog.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n=0: state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, timeout=0, hold_cnt=0.
  - Reset asserted mid-grant drops gnt_vld immediately, without waiting for a clock edge.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - If req=0, stay in IDLE; all outputs hold, gnt_vld stays 0.
  - If req!=0, pick the first set bit scanning upward from ptr, wrapping 7 to 0.
  - At that edge: gnt_idx<=pick, gnt_vld<=1, hold_cnt<=0, state<=GRANT.
  - Latency: a request present in cycle N gives gnt_vld=1 in cycle N+1.
- GRANT: release occurs at the edge where any of the following holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- Without release: hold_cnt increments; gnt_idx and gnt_vld hold.
- On release:
  - gnt_vld<=0, state<=IDLE.
  - ptr<=gnt_idx+1, modulo 8 (7 wraps to 0).
  - timeout<=1 only if (c) is true and both (a) and (b) are false; otherwise timeout<=0.
- timeout is 1 for exactly one cycle; in that cycle gnt_vld=0.
- gnt_vld is high for at most MAX_HOLD consecutive cycles.
- Break-before-make:
  - At least one cycle of gnt_vld=0 separates any two grants, including a re-grant to the same requester.
  - The decoder output is therefore all-zero for at least one cycle between owners.
- gnt_idx retains the last granted value while gnt_vld=0; it changes only at a grant edge.
- Changes on req bits other than gnt_idx during GRANT are ignored.
- done while in IDLE is ignored.
- ptr advances only on release, never on the pick itself.
- Starvation bound: a requester that holds req high is granted within 7 grants.

Decomposition:
- Shared package holds:
  - N_REQ, IDX_W and the default MAX_HOLD;
  - the state enum (IDLE, GRANT);
  - a grant-index typedef, logic [IDX_W-1:0], which the decoder and its consumers also use.
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Function: rotate by ptr, apply fixed priority with the lowest bit first, rotate back.
- The FSM, hold counter and output registers stay in rr_arbiter_8.

Test Plan:
1. Reset and idle: hold rst_n=0 with req=8'hFF -> gnt_vld=0, gnt_idx=0, timeout=0. Release rst_n with req=0 -> gnt_vld stays 0 for 20 cycles.
2. Single request: req=8'h20 in cycle N -> gnt_vld=1, gnt_idx=5 in cycle N+1. done pulse in cycle N+3 -> gnt_vld=0 in cycle N+4. Next grant with req=8'hFF is gnt_idx=6.
3. Full round-robin: req=8'hFF held, done pulsed on the second cycle of each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0. Every grant has gnt_vld low for >=1 cycle in between.
4. Wrap: after a grant to 6 is released (ptr=7), req=8'h03 -> gnt_idx=0. After that release, req=8'h03 -> gnt_idx=1.
5. Watchdog (MAX_HOLD=4): req=8'h08 held, done=0 -> gnt_vld high exactly 4 cycles. timeout=1 for 1 cycle while gnt_vld=0. Requester 3 is re-granted the next cycle. Same run with done=1 on the 4th cycle -> timeout stays 0.
6. Drop and reset: grant to idx 2, then req[2]=0 -> gnt_vld=0 at the next edge with timeout=0. New grant, then assert rst_n=0 mid-grant -> gnt_vld falls asynchronously and ptr resets to 0 (next grant with req=8'hFF is idx 0).
